// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station issue unit: entry field
// positions, FSM state encoding and width constants.
package rs_pkg;

    localparam int RS_DATA_W = 144;
    localparam int RS_TAG_W  = 32;
    localparam int RS_WORD_W = 32;
    localparam int RS_OP_W   = 8;
    localparam int RS_DEST_W = 5;

    localparam int OP_MSB    = 143;
    localparam int OP_LSB    = 136;
    localparam int TAG_MSB   = 135;
    localparam int TAG_LSB   = 104;
    localparam int SRCA_MSB  = 103;
    localparam int SRCA_LSB  = 72;
    localparam int SRCB_MSB  = 71;
    localparam int SRCB_LSB  = 40;
    localparam int IMM_MSB   = 39;
    localparam int IMM_LSB   = 8;
    localparam int DEST_MSB  = 7;
    localparam int DEST_LSB  = 3;
    localparam int FLAGA_BIT = 2;
    localparam int FLAGB_BIT = 1;
    localparam int VALID_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } rs_state_e;

endpackage

// File: rtl/rs_operand_wakeup.sv
// Single-operand CDB snoop: a pending operand whose producer tag matches the
// broadcast captures the broadcast data and becomes ready.
module rs_operand_wakeup #(
    parameter int TAG_WIDTH  = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [WORD_WIDTH-1:0] cdb_data,
    input  logic [WORD_WIDTH-1:0] src,
    input  logic                  flag,
    output logic [WORD_WIDTH-1:0] src_woken,
    output logic                  flag_woken
);

    logic hit;

    // While pending, the low TAG_WIDTH bits of the source field carry the producer tag.
    assign hit        = cdb_valid && !flag && (src[TAG_WIDTH-1:0] == cdb_tag);
    assign src_woken  = hit ? cdb_data : src;
    assign flag_woken = flag | hit;

endmodule

// File: rtl/rs_issue_unit.sv
// Reservation-station read side: pops the head entry, wakes operands off the
// CDB and issues to one FU. Optional macro RS_ISSUE_CDB_BYPASS_EN.
module rs_issue_unit
    import rs_pkg::*;
#(
    parameter int DATA_WIDTH = 144,
    parameter int TAG_WIDTH  = 32,
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  RSRCLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] RSHeadElement,
    input  logic                  RSBufEmpty,
    output logic                  RSRE,
    input  logic                  CDBValid,
    input  logic [TAG_WIDTH-1:0]  CDBTag,
    input  logic [WORD_WIDTH-1:0] CDBData,
    input  logic                  Branch,
    input  logic [TAG_WIDTH-1:0]  BranchTag,
    output logic                  FUValid,
    input  logic                  FUReady,
    output logic [RS_OP_W-1:0]    FUOp,
    output logic [TAG_WIDTH-1:0]  FUTag,
    output logic [WORD_WIDTH-1:0] FUDataA,
    output logic [WORD_WIDTH-1:0] FUDataB,
    output logic [WORD_WIDTH-1:0] FUImm,
    output logic [RS_DEST_W-1:0]  FUDest,
    output logic [CNT_WIDTH-1:0]  IssueCount
);

    rs_state_e             state, state_next;
    logic [DATA_WIDTH-1:0] hold, src_entry, woken;
    logic [WORD_WIDTH-1:0] a_woken, b_woken;
    logic                  a_flag, b_flag;
    logic                  load, squash, count_inc, wait_ready;
    logic [CNT_WIDTH-1:0]  count;

    // A held entry younger than the mispredicted branch is discarded.
    assign squash = Branch && (state != IDLE) && (hold[TAG_MSB:TAG_LSB] > BranchTag);

    assign load = !RSBufEmpty && !Branch &&
                  ((state == IDLE) || ((state == ISSUE) && FUReady));
    assign count_inc = (state == ISSUE) && FUReady && !squash;
    assign RSRE = load && !Reset;

    // Wakeup operates on the entry being loaded, otherwise on the held one.
    assign src_entry = load ? RSHeadElement : hold;

    rs_operand_wakeup #(.TAG_WIDTH(TAG_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_wake_a (
        .cdb_valid (CDBValid),
        .cdb_tag   (CDBTag),
        .cdb_data  (CDBData),
        .src       (src_entry[SRCA_MSB:SRCA_LSB]),
        .flag      (src_entry[FLAGA_BIT]),
        .src_woken (a_woken),
        .flag_woken(a_flag)
    );

    rs_operand_wakeup #(.TAG_WIDTH(TAG_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_wake_b (
        .cdb_valid (CDBValid),
        .cdb_tag   (CDBTag),
        .cdb_data  (CDBData),
        .src       (src_entry[SRCB_MSB:SRCB_LSB]),
        .flag      (src_entry[FLAGB_BIT]),
        .src_woken (b_woken),
        .flag_woken(b_flag)
    );

    always_comb begin
        woken                     = src_entry;
        woken[SRCA_MSB:SRCA_LSB]  = a_woken;
        woken[FLAGA_BIT]          = a_flag;
        woken[SRCB_MSB:SRCB_LSB]  = b_woken;
        woken[FLAGB_BIT]          = b_flag;
    end

`ifdef RS_ISSUE_CDB_BYPASS_EN
    assign wait_ready = a_flag && b_flag;
`else
    assign wait_ready = hold[FLAGA_BIT] && hold[FLAGB_BIT];
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            WAIT:    if (squash) state_next = IDLE;
                     else if (wait_ready) state_next = ISSUE;
            ISSUE:   if (squash || FUReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (load) state_next = (a_flag && b_flag) ? ISSUE : WAIT;
    end

    always_ff @(posedge RSRCLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            hold  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            hold  <= woken;
            if (count_inc) count <= count + CNT_WIDTH'(1);
        end
    end

    assign FUValid    = (state == ISSUE);
    assign FUOp       = hold[OP_MSB:OP_LSB];
    assign FUTag      = hold[TAG_MSB:TAG_LSB];
    assign FUDataA    = hold[SRCA_MSB:SRCA_LSB];
    assign FUDataB    = hold[SRCB_MSB:SRCB_LSB];
    assign FUImm      = hold[IMM_MSB:IMM_LSB];
    assign FUDest     = hold[DEST_MSB:DEST_LSB];
    assign IssueCount = count;

endmodule

// File: tb/tb_rs_issue_unit.sv
// Directed bench for rs_issue_unit; a small queue models the RS FIFO feeding the head.
module tb_rs_issue_unit;

    logic         RSRCLK = 1'b0;
    logic         Reset;
    logic [143:0] RSHeadElement;
    logic         RSBufEmpty;
    logic         RSRE;
    logic         CDBValid;
    logic [31:0]  CDBTag;
    logic [31:0]  CDBData;
    logic         Branch;
    logic [31:0]  BranchTag;
    logic         FUValid;
    logic         FUReady;
    logic [7:0]   FUOp;
    logic [31:0]  FUTag;
    logic [31:0]  FUDataA;
    logic [31:0]  FUDataB;
    logic [31:0]  FUImm;
    logic [4:0]   FUDest;
    logic [15:0]  IssueCount;

    int checks = 0;
    int errors = 0;
    logic [143:0] q[$];
    logic pop;

    always #5 RSRCLK = ~RSRCLK;

    rs_issue_unit dut (
        .RSRCLK       (RSRCLK),
        .Reset        (Reset),
        .RSHeadElement(RSHeadElement),
        .RSBufEmpty   (RSBufEmpty),
        .RSRE         (RSRE),
        .CDBValid     (CDBValid),
        .CDBTag       (CDBTag),
        .CDBData      (CDBData),
        .Branch       (Branch),
        .BranchTag    (BranchTag),
        .FUValid      (FUValid),
        .FUReady      (FUReady),
        .FUOp         (FUOp),
        .FUTag        (FUTag),
        .FUDataA      (FUDataA),
        .FUDataB      (FUDataB),
        .FUImm        (FUImm),
        .FUDest       (FUDest),
        .IssueCount   (IssueCount)
    );

    function automatic logic [143:0] mk(input logic [7:0] op, input logic [31:0] tag,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] imm, input logic [4:0] dest,
                                        input logic fa, input logic fb);
        return {op, tag, a, b, imm, dest, fa, fb, 1'b1};
    endfunction

    task automatic refresh();
        if (q.size() > 0) begin
            RSHeadElement = q[0];
            RSBufEmpty    = 1'b0;
        end else begin
            RSHeadElement = '0;
            RSBufEmpty    = 1'b1;
        end
        #1;
    endtask

    task automatic tick();
        pop = RSRE;
        @(posedge RSRCLK);
        #1;
        if (pop && q.size() > 0) q.delete(0);
        refresh();
    endtask

    task automatic test_reset();
        Reset = 1'b1; CDBValid = 0; CDBTag = 0; CDBData = 0;
        Branch = 0; BranchTag = 0; FUReady = 0;
        refresh();
        tick(); tick();
        checks++; if (FUValid !== 1'b0) begin errors++; $display("FAIL reset_fuvalid got %h exp 0", FUValid); end
        checks++; if (IssueCount !== 16'h0) begin errors++; $display("FAIL reset_count got %h exp 0", IssueCount); end
        checks++; if (RSRE !== 1'b0) begin errors++; $display("FAIL reset_rsre got %h exp 0", RSRE); end
        checks++; if (FUTag !== 32'h0 || FUDataA !== 32'h0 || FUOp !== 8'h0) begin
            errors++; $display("FAIL reset_fields got tag %h a %h op %h exp 0", FUTag, FUDataA, FUOp); end
        Reset = 1'b0;
        refresh();
    endtask

    task automatic test_ready();
        FUReady = 1'b1;
        q.push_back(mk(8'h01, 32'h10, 32'hA, 32'hB, 32'hC, 5'd1, 1'b1, 1'b1));
        refresh();
        checks++; if (RSRE !== 1'b1) begin errors++; $display("FAIL ready_rsre got %h exp 1", RSRE); end
        tick();
        checks++; if (FUValid !== 1'b1 || FUTag !== 32'h10) begin
            errors++; $display("FAIL ready_issue got valid %h tag %h exp 1 10", FUValid, FUTag); end
        checks++; if (RSRE !== 1'b0) begin errors++; $display("FAIL ready_empty_rsre got %h exp 0", RSRE); end
        tick();
        checks++; if (IssueCount !== 16'd1 || FUValid !== 1'b0) begin
            errors++; $display("FAIL ready_count got count %h valid %h exp 1 0", IssueCount, FUValid); end
    endtask

    task automatic test_pending();
        q.push_back(mk(8'h02, 32'h11, 32'h7, 32'h22, 32'h99, 5'd3, 1'b0, 1'b1));
        refresh();
        tick();
        checks++; if (FUValid !== 1'b0) begin errors++; $display("FAIL pend_wait got %h exp 0", FUValid); end
        CDBValid = 1; CDBTag = 32'h8; CDBData = 32'h1234;
        tick();
        CDBValid = 0;
        checks++; if (FUDataA !== 32'h7 || FUValid !== 1'b0) begin
            errors++; $display("FAIL pend_mismatch got a %h valid %h exp 7 0", FUDataA, FUValid); end
        tick();
        CDBValid = 1; CDBTag = 32'h7; CDBData = 32'hDEADBEEF;
        tick();
        CDBValid = 0;
        checks++; if (FUDataA !== 32'hDEADBEEF) begin errors++; $display("FAIL pend_capture got %h exp deadbeef", FUDataA); end
`ifndef RS_ISSUE_CDB_BYPASS_EN
        checks++; if (FUValid !== 1'b0) begin errors++; $display("FAIL pend_extra_wait got %h exp 0", FUValid); end
        tick();
`endif
        checks++; if (FUValid !== 1'b1) begin errors++; $display("FAIL pend_issue got %h exp 1", FUValid); end
        checks++; if (FUDataB !== 32'h22 || FUImm !== 32'h99 || FUDest !== 5'd3 || FUOp !== 8'h02) begin
            errors++; $display("FAIL pend_fields got b %h imm %h dest %h op %h exp 22 99 3 02", FUDataB, FUImm, FUDest, FUOp); end
        tick();
        checks++; if (IssueCount !== 16'd2) begin errors++; $display("FAIL pend_count got %h exp 2", IssueCount); end
    endtask

    task automatic test_backpressure();
        FUReady = 1'b0;
        for (int i = 0; i < 3; i++)
            q.push_back(mk(8'h04, 32'h30 + i, 32'h100 + i, 32'h200, 32'h0, 5'd4, 1'b1, 1'b1));
        refresh();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (FUValid !== 1'b1 || FUTag !== 32'h30 || FUDataA !== 32'h100 || RSRE !== 1'b0) begin
                errors++; $display("FAIL bp_hold got valid %h tag %h a %h rsre %h exp 1 30 100 0", FUValid, FUTag, FUDataA, RSRE); end
            tick();
        end
        FUReady = 1'b1;
        refresh();
        checks++; if (RSRE !== 1'b1) begin errors++; $display("FAIL bp_rsre got %h exp 1", RSRE); end
        tick();
        checks++; if (FUValid !== 1'b1 || FUTag !== 32'h31 || IssueCount !== 16'd3) begin
            errors++; $display("FAIL bp_b2b1 got valid %h tag %h count %h exp 1 31 3", FUValid, FUTag, IssueCount); end
        tick();
        checks++; if (FUValid !== 1'b1 || FUTag !== 32'h32 || IssueCount !== 16'd4) begin
            errors++; $display("FAIL bp_b2b2 got valid %h tag %h count %h exp 1 32 4", FUValid, FUTag, IssueCount); end
        tick();
        checks++; if (FUValid !== 1'b0 || IssueCount !== 16'd5) begin
            errors++; $display("FAIL bp_done got valid %h count %h exp 0 5", FUValid, IssueCount); end
        FUReady = 1'b0;
    endtask

    task automatic test_squash();
        q.push_back(mk(8'h05, 32'h20, 32'h1, 32'h2, 32'h0, 5'd5, 1'b1, 1'b1));
        refresh();
        tick();
        Branch = 1; BranchTag = 32'h18; FUReady = 1;
        tick();
        Branch = 0; FUReady = 0;
        checks++; if (FUValid !== 1'b0 || IssueCount !== 16'd5) begin
            errors++; $display("FAIL squash_younger got valid %h count %h exp 0 5", FUValid, IssueCount); end
        q.push_back(mk(8'h05, 32'h20, 32'h1, 32'h2, 32'h0, 5'd5, 1'b1, 1'b1));
        refresh();
        tick();
        Branch = 1; BranchTag = 32'h20; FUReady = 1;
        tick();
        Branch = 0; FUReady = 0;
        checks++; if (IssueCount !== 16'd6) begin errors++; $display("FAIL squash_equal_kept got %h exp 6", IssueCount); end
        Branch = 1; BranchTag = 32'h0;
        q.push_back(mk(8'h06, 32'h22, 32'h1, 32'h2, 32'h0, 5'd6, 1'b1, 1'b1));
        refresh();
        checks++; if (RSRE !== 1'b0) begin errors++; $display("FAIL branch_rsre got %h exp 0", RSRE); end
        tick();
        checks++; if (FUValid !== 1'b0) begin errors++; $display("FAIL branch_noload got %h exp 0", FUValid); end
        Branch = 0;
        refresh();
        checks++; if (RSRE !== 1'b1) begin errors++; $display("FAIL branch_release_rsre got %h exp 1", RSRE); end
        tick();
        checks++; if (FUValid !== 1'b1 || FUTag !== 32'h22) begin
            errors++; $display("FAIL branch_release_issue got valid %h tag %h exp 1 22", FUValid, FUTag); end
        FUReady = 1;
        tick();
        FUReady = 0;
        checks++; if (IssueCount !== 16'd7) begin errors++; $display("FAIL branch_release_count got %h exp 7", IssueCount); end
    endtask

    task automatic test_dual_wakeup_wrap();
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        refresh();
        checks++; if (IssueCount !== 16'd0) begin errors++; $display("FAIL wrap_clear got %h exp 0", IssueCount); end
        for (int i = 0; i < 65535; i++)
            q.push_back(mk(8'h07, i, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1));
        FUReady = 1'b1;
        refresh();
        for (int i = 0; i < 65536; i++) tick();
        checks++; if (IssueCount !== 16'hFFFF || FUValid !== 1'b0) begin
            errors++; $display("FAIL wrap_preload got count %h valid %h exp ffff 0", IssueCount, FUValid); end
        q.push_back(mk(8'h08, 32'h40, 32'h5, 32'h5, 32'h0, 5'd8, 1'b0, 1'b0));
        refresh();
        tick();
        CDBValid = 1; CDBTag = 32'h5; CDBData = 32'hCAFE0001;
        tick();
        CDBValid = 0;
        checks++; if (FUDataA !== 32'hCAFE0001 || FUDataB !== 32'hCAFE0001) begin
            errors++; $display("FAIL dual_wake got a %h b %h exp cafe0001 cafe0001", FUDataA, FUDataB); end
`ifndef RS_ISSUE_CDB_BYPASS_EN
        tick();
`endif
        checks++; if (FUValid !== 1'b1 || IssueCount !== 16'hFFFF) begin
            errors++; $display("FAIL dual_issue got valid %h count %h exp 1 ffff", FUValid, IssueCount); end
        tick();
        checks++; if (IssueCount !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h exp 0", IssueCount); end
        FUReady = 1'b0;
    endtask

    task automatic test_async_reset();
        q.push_back(mk(8'h09, 32'h50, 32'h1, 32'h2, 32'h3, 5'd9, 1'b1, 1'b1));
        refresh();
        tick();
        checks++; if (FUValid !== 1'b1) begin errors++; $display("FAIL areset_pre got %h exp 1", FUValid); end
        #2;
        Reset = 1'b1;
        #1;
        checks++; if (FUValid !== 1'b0 || IssueCount !== 16'h0 || FUTag !== 32'h0) begin
            errors++; $display("FAIL areset_now got valid %h count %h tag %h exp 0 0 0", FUValid, IssueCount, FUTag); end
        q.push_back(mk(8'h0A, 32'h51, 32'h1, 32'h2, 32'h3, 5'd10, 1'b1, 1'b1));
        refresh();
        checks++; if (RSRE !== 1'b0) begin errors++; $display("FAIL areset_rsre got %h exp 0", RSRE); end
        tick();
        checks++; if (FUValid !== 1'b0 || RSRE !== 1'b0) begin
            errors++; $display("FAIL areset_hold got valid %h rsre %h exp 0 0", FUValid, RSRE); end
        Reset = 1'b0;
        refresh();
        checks++; if (RSRE !== 1'b1) begin errors++; $display("FAIL areset_release got %h exp 1", RSRE); end
        tick();
        checks++; if (FUValid !== 1'b1 || FUTag !== 32'h51) begin
            errors++; $display("FAIL areset_reload got valid %h tag %h exp 1 51", FUValid, FUTag); end
        FUReady = 1'b1;
        tick();
        FUReady = 1'b0;
        checks++; if (IssueCount !== 16'd1) begin errors++; $display("FAIL areset_count got %h exp 1", IssueCount); end
    endtask

    initial begin
        test_reset();
        test_ready();
        test_pending();
        test_backpressure();
        test_squash();
        test_dual_wakeup_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_issue_unit.md
Name: rs_issue_unit

Overview:
- Consumer (read side) of the reservation-station FIFO.
- Pops the head entry into a holding register and snoops the CDB to wake pending operands.
- Issues the entry to one functional unit (FU) with a valid/ready handshake.
- Discards the held entry on a branch squash when the entry is younger than the branch.

Parameters:
- DATA_WIDTH, 144, width of an RS entry
- TAG_WIDTH, 32, instruction/producer tag width
- WORD_WIDTH, 32, operand width
- CNT_WIDTH, 16, width of the issued-instruction counter

Ports:
- RSRCLK  input  1  single clock; also the RS read clock
- Reset  input  1  asynchronous, active-high reset
- RSHeadElement  input  144  current RS head entry
- RSBufEmpty  input  1  RS holds no entries
- RSRE  output  1  pop strobe; RS advances its head on this cycle's edge
- CDBValid  input  1  common data bus broadcast valid
- CDBTag  input  32  producer tag on the CDB
- CDBData  input  32  result on the CDB
- Branch  input  1  mispredict squash
- BranchTag  input  32  tag of the mispredicted branch
- FUValid  output  1  issue request to the FU
- FUReady  input  1  FU accepts the request
- FUOp  output  8  opcode/control
- FUTag  output  32  instruction tag
- FUDataA  output  32  operand A
- FUDataB  output  32  operand B
- FUImm  output  32  immediate
- FUDest  output  5  destination register
- IssueCount  output  16  issued-instruction count

Behaviour:
- Entry layout:
  - [143:136] Op; [135:104] InstTag; [103:72] SrcA (data if FlagA=1, else producer tag); [71:40] SrcB; [39:8] Imm; [7:3] Dest.
  - [2] FlagA, [1] FlagB: 1 = data ready.
  - [0] Valid.
- Reset (async): state IDLE, holding register H = 0, IssueCount = 0, FUValid = 0. All FU* outputs are driven from H, so they read 0. RSRE = 0.
- Wakeup, applied every cycle to H and to an entry being loaded:
  - If CDBValid, FlagA = 0 and SrcA == CDBTag, then SrcA <= CDBData and FlagA <= 1. Same rule for B.
  - Both operands may wake on the same broadcast.
- FSM states: IDLE, WAIT, ISSUE.
  - IDLE: if !RSBufEmpty and !Branch, then H <= woken head and RSRE = 1 (combinational, one cycle). Next state is ISSUE if both woken flags = 1, else WAIT. Otherwise stay in IDLE.
  - WAIT: apply wakeup. Move to ISSUE when both registered flags = 1. This costs one cycle after the completing CDB broadcast (see macro).
  - ISSUE: FUValid = 1; FU* outputs are stable from H. If FUReady, the handshake completes and IssueCount increments (wraps at 2^16-1 to 0).
    - On the same edge, if !RSBufEmpty, load the next head (RSRE = 1) and go to ISSUE or WAIT by its flags. This gives back-to-back issue at 1 per cycle.
    - Otherwise go to IDLE.
  - ISSUE without FUReady: hold everything, and keep FUValid asserted.
- Latency: entry already ready and FU ready gives head-present to FUValid in 1 cycle.
- Branch:
  - In any state, if Branch = 1 and H is held (WAIT or ISSUE) with H.InstTag > BranchTag (unsigned): H is squashed, next state is IDLE, FUValid drops on the next cycle.
  - The squash wins over a coincident FUReady: no count increment, and the FU also honours Branch.
  - If H.InstTag <= BranchTag, H is kept.
  - RSRE is never asserted while Branch = 1 (the RS is flushing).
- RSBufEmpty = 1: RSRE is never asserted.
- Reset mid-handshake: FUValid drops asynchronously and H is lost.

Optional Feature:
- Macro: RS_ISSUE_CDB_BYPASS_EN.
- Defined: the WAIT to ISSUE decision uses post-wakeup flags, so a broadcast completing the last operand moves to ISSUE on that same edge. The captured data goes into H on that edge, and FUValid rises the next cycle.
- Undefined: the decision uses registered flags only, giving one extra WAIT cycle.

Decomposition:
- Package rs_pkg holds:
  - entry field position localparams (OP_MSB … VALID_BIT)
  - state encoding typedef (IDLE = 2'd0, WAIT = 2'd1, ISSUE = 2'd2)
  - width constants
- One sub-module, rs_operand_wakeup: combinational tag compare and capture for a single operand, instantiated twice (A and B).

Test Plan:
- Ready entry, FUReady = 1: entry pushed with both flags = 1 and Tag 0x10 -> RSRE pulses cycle 1, FUValid cycle 2 with FUTag = 0x10, IssueCount = 1.
- Pending operand: FlagA = 0, SrcA = 0x7. Broadcast CDB tag 0x7 with data 0xDEADBEEF three cycles later -> FUDataA = 0xDEADBEEF. FUValid is 1 cycle later with the macro, 2 cycles later without.
- Backpressure: FUReady = 0 for 4 cycles with 3 entries queued -> FUValid held, outputs stable, RSRE = 0. Then FUReady = 1 for 3 cycles -> 3 consecutive issues, IssueCount = 3.
- Squash: H.InstTag = 0x20 in ISSUE, Branch = 1, BranchTag = 0x18, FUReady = 1 -> no issue, count unchanged, state IDLE. Repeat with BranchTag = 0x20 -> entry issues.
- Dual wakeup plus count wrap: FlagA = FlagB = 0, both SrcA and SrcB = 0x5, single CDB broadcast -> both captured. Preload IssueCount = 0xFFFF -> becomes 0x0000 after that issue.
- Async reset asserted during ISSUE -> FUValid = 0 immediately, IssueCount = 0, RSRE = 0 until Reset is released and RSBufEmpty = 0.
